add16_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for 16-bit add and subtract.
- Shares one fulladder4 slice over WIDTH/4 consecutive cycles. Carry is held in a register between slices.
- Area-reduced alternative to the ripple fulladder16. Sits behind the ALU operand registers.
- Interface: start/busy/done handshake with registered result.

---
 rtl/add16_seq_ctrl.sv | 92 +++++++++
 tb/tb_add16_seq_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/add16_seq_ctrl.sv
// add16_seq_ctrl: multi-cycle add/subtract sequencer built on one shared 4-bit adder slice
module fulladder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic c;
  // ripple four bit cells from ci to co
  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module add16_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic             OFL
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] opa, opb;
  logic [IW-1:0] idx;
  logic carry, accept, last, sco;
  logic [3:0] ss;
  fulladder4 u_fa (
    .a (opa[4*idx +: 4]),
    .b (opb[4*idx +: 4]),
    .ci(carry),
    .s (ss),
    .co(sco)
  );
  // next state and handshake outputs; a start is taken only when not running
  always_comb begin
    accept = start && (state != RUN);
    last = idx == LAST;
    state_n = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
    busy = state == RUN;
    done = state == DONE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // operand latch, per-slice accumulate, and final flag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      opa <= '0;
      opb <= '0;
      carry <= 1'b0;
      idx <= '0;
      SUM <= '0;
      CO <= 1'b0;
      OFL <= 1'b0;
    end else if (accept) begin
      opa <= A;
      opb <= sub ? ~B : B;
      carry <= sub;
      idx <= '0;
      SUM <= '0;
    end else if (state == RUN) begin
      SUM[4*idx +: 4] <= ss;
      carry <= sco;
      idx <= last ? '0 : idx + IW'(1);
      if (last) begin
        CO <= sco;
        OFL <= (opa[WIDTH-1] == opb[WIDTH-1]) && (ss[3] != opa[WIDTH-1]);
      end
    end
  end
endmodule

// File: tb/tb_add16_seq_ctrl.sv
// tb_add16_seq_ctrl: scoreboard bench for the sequential add/subtract unit
module tb_add16_seq_ctrl;
  logic clk = 0, rst = 1, start = 0, sub = 0;
  logic [15:0] A = '0, B = '0;
  logic busy, done, CO, OFL;
  logic [15:0] SUM;
  int vectors = 0, errors = 0;
  int m = 0;
  logic [17:0] q[$];
  logic [15:0] hs = '0;
  logic hc = 0, ho = 0;

  add16_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .SUM(SUM), .CO(CO), .OFL(OFL)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    int ra, rb, r, u;
    ra = $signed(a);
    rb = $signed(b);
    r = s ? ra - rb : ra + rb;
    u = s ? int'(a) + (65535 - int'(b)) + 1 : int'(a) + int'(b);
    return {u[15:0], u > 65535, (r > 32767) || (r < -32768)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // cycle-level model: phase 0 idle, 1..4 running, 5 result cycle
  always @(posedge clk) begin
    if (rst) begin
      m = 0;
      q.delete();
    end else if (m == 0 || m == 5) begin
      if (start) begin
        q.push_back(ref_op(A, B, sub));
        m = 1;
      end else m = 0;
    end else m = m + 1;
  end

  // monitor: handshake every cycle, result on done, held result while idle
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, (m >= 1 && m <= 4));
      check("done", done, m == 5);
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [17:0] e;
          e = q.pop_front();
          check("sum", SUM, e[17:2]);
          check("co", CO, e[1]);
          check("ofl", OFL, e[0]);
          {hs, hc, ho} = e;
        end
      end else if (m == 0) begin
        check("hold_sum", SUM, hs);
        check("hold_co", CO, hc);
        check("hold_ofl", OFL, ho);
      end
    end else begin
      hs = '0;
      hc = 0;
      ho = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s);
    A = a; B = b; sub = s; start = 1;
    step(1);
    start = 0;
    A = $urandom; B = $urandom; sub = $urandom;
  endtask

  initial begin
    step(2);
    rst = 0;
    step(2);
    op(16'h1234, 16'h4321, 0); step(5);
    op(16'hFFFF, 16'h0001, 0); step(5);
    op(16'h7FFF, 16'h0001, 0); step(5);
    op(16'h0005, 16'h0007, 1); step(5);
    op(16'h8000, 16'h0001, 1); step(5);
    op(16'h0001, 16'h0001, 0); step(1);
    op(16'h1000, 16'h1000, 0); step(12);
    A = 16'h00FF; B = 16'h0001; sub = 0; start = 1;
    step(5);
    A = 16'h0F00; B = 16'h0100;
    step(1);
    start = 0;
    step(6);
    op(16'h1111, 16'h2222, 0); step(1);
    rst = 1; step(1);
    rst = 0; step(3);
    op(16'hA5A5, 16'h5A5A, 1); step(6);
    for (int i = 0; i < 500; i++) begin
      A = $urandom; B = $urandom; sub = $urandom;
      start = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 60) == 0);
      step(1);
    end
    rst = 0; start = 0;
    step(8);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
